// File: rtl/vga_frame_monitor.sv
// VGA output monitor: recovers frame/line timing from raw syncs, checks sync
// widths and periods against the configured mode and reports a per-frame CRC-16.
module vga_frame_monitor #(
  parameter int COLOR_BITS = 6,
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_POL   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_en,
  input  logic [COLOR_BITS-1:0] rgb,
  input  logic                  hsync,
  input  logic                  vsync,
  output logic                  frame_valid,
  output logic [15:0]           frame_crc,
  output logic [2:0]            frame_err,
  output logic [7:0]            frame_cnt,
  output logic                  locked
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL) + 1;
  localparam int VW = $clog2(V_TOTAL) + 1;

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_SYNC - 1);
  localparam logic [HW-1:0] H_ACT_LO    = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_HI    = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [HW-1:0] H_MAX       = '1;
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_LAST = VW'(V_SYNC - 1);
  localparam logic [VW-1:0] V_ACT_LO    = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_HI    = VW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [VW-1:0] V_MAX       = '1;

  // SEARCH: wait for the first vsync edge | TRACK: report on every later vsync edge
  typedef enum logic {SEARCH, TRACK} state_t;
  state_t state, state_nxt;

  logic [COLOR_BITS-1:0] rgb_s1, rgb_s2;
  logic                  hs_s1, hs_s2, vs_s1, vs_s2;
  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic                  v_pend, h_chk_en;
  logic [15:0]           crc, crc_nxt;
  logic [2:0]            err_q, err_set, err_rep;
  logic                  report, pix_act;
  logic                  hs_norm, vs_norm, h_edge, h_fall, v_edge, v_fall;

  assign hs_norm = (SYNC_POL != 0) ? hsync : ~hsync;
  assign vs_norm = (SYNC_POL != 0) ? vsync : ~vsync;
  assign h_edge  = hs_s1 & ~hs_s2;
  assign h_fall  = ~hs_s1 & hs_s2;
  assign v_edge  = vs_s1 & ~vs_s2;
  assign v_fall  = ~vs_s1 & vs_s2;

  // h_cnt/v_cnt track the pixel held in stage s2.
  assign pix_act = (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI) &&
                   (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);

  function automatic logic [15:0] crc_feed(input logic [15:0] c, input logic [COLOR_BITS-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = COLOR_BITS - 1; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  assign crc_nxt = pix_act ? crc_feed(crc, rgb_s2) : crc;
  assign err_rep = err_q | err_set;

  always_comb begin
    state_nxt = state;
    report    = 1'b0;
    err_set   = 3'b000;
    if (pix_en) begin
      if (state == TRACK) begin
        if (h_chk_en) begin
          err_set[0] = h_edge ? (h_cnt != H_LAST) : (h_cnt == H_LAST);
          err_set[1] = h_fall && (h_cnt != H_SYNC_LAST);
        end
        err_set[2] = (v_edge && (v_cnt != V_LAST)) || (v_fall && (v_cnt != V_SYNC_LAST));
        report     = v_edge;
      end else if (v_edge) begin
        state_nxt = TRACK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SEARCH;
      rgb_s1      <= '0;
      rgb_s2      <= '0;
      hs_s1       <= 1'b0;
      hs_s2       <= 1'b0;
      vs_s1       <= 1'b0;
      vs_s2       <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      v_pend      <= 1'b0;
      h_chk_en    <= 1'b0;
      crc         <= 16'hFFFF;
      err_q       <= 3'b000;
      frame_valid <= 1'b0;
      frame_crc   <= 16'h0000;
      frame_err   <= 3'b000;
      frame_cnt   <= 8'd0;
      locked      <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_valid <= report;
      if (report) begin
        frame_crc <= crc_nxt;
        frame_err <= err_rep;
        frame_cnt <= frame_cnt + 8'd1;
        locked    <= (err_rep == 3'b000);
      end
      if (pix_en) begin
        rgb_s1 <= rgb;
        hs_s1  <= hs_norm;
        vs_s1  <= vs_norm;
        rgb_s2 <= rgb_s1;
        hs_s2  <= hs_s1;
        vs_s2  <= vs_s1;
        crc    <= v_edge ? 16'hFFFF : crc_nxt;
        err_q  <= report ? 3'b000 : err_rep;
        if (h_edge) h_cnt <= '0;
        else if (h_cnt != H_MAX) h_cnt <= h_cnt + HW'(1);
        // Line 0 starts at the first hsync edge at or after the vsync edge.
        if (v_edge) begin
          v_cnt  <= '0;
          v_pend <= ~h_edge;
        end else if (h_edge) begin
          if (v_pend) v_pend <= 1'b0;
          else if (v_cnt != V_MAX) v_cnt <= v_cnt + VW'(1);
        end
        if (state != TRACK) h_chk_en <= 1'b0;
        else if (h_edge) h_chk_en <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor: a reduced 6-bit active-low mode and a 12-bit
// active-high 4x3 mode, each checked through a queue of expected frame reports.
`timescale 1ns/1ps
module tb_vga_frame_monitor;

  localparam int A_CB = 6,  A_HA = 16, A_HF = 2, A_HS = 4, A_HB = 3;
  localparam int A_VA = 8,  A_VF = 1,  A_VS = 2, A_VB = 2;
  localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
  localparam int B_CB = 12, B_HA = 4, B_HF = 1, B_HS = 1, B_HB = 1;
  localparam int B_VA = 3,  B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VA + B_VF + B_VS + B_VB;

  typedef struct packed {
    logic [15:0] crc;
    logic [2:0]  err;
    logic [7:0]  cnt;
    logic        lck;
  } rep_t;

  logic        clk = 1'b0;
  logic        a_rst_n, a_pix_en, a_hs, a_vs, a_fv, a_lck;
  logic [5:0]  a_rgb;
  logic [15:0] a_crc;
  logic [2:0]  a_err;
  logic [7:0]  a_cnt;
  logic        b_rst_n, b_pix_en, b_hs, b_vs, b_fv, b_lck;
  logic [11:0] b_rgb;
  logic [15:0] b_crc;
  logic [2:0]  b_err;
  logic [7:0]  b_cnt;

  rep_t qa[$], qb[$];
  rep_t ea, eb;
  int   checks = 0, failures = 0;
  int   a_pulses = 0, b_pulses = 0;
  int   a_exp_cnt = 0, b_exp_cnt = 0;
  logic a_fv_prev = 1'b0, b_fv_prev = 1'b0;

  always #5 clk = ~clk;

  vga_frame_monitor #(
    .COLOR_BITS(A_CB), .H_ACTIVE(A_HA), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
    .V_ACTIVE(A_VA), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB), .SYNC_POL(0)
  ) dut_a (
    .clk(clk), .rst_n(a_rst_n), .pix_en(a_pix_en), .rgb(a_rgb), .hsync(a_hs), .vsync(a_vs),
    .frame_valid(a_fv), .frame_crc(a_crc), .frame_err(a_err), .frame_cnt(a_cnt), .locked(a_lck)
  );

  vga_frame_monitor #(
    .COLOR_BITS(B_CB), .H_ACTIVE(B_HA), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_ACTIVE(B_VA), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB), .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .rst_n(b_rst_n), .pix_en(b_pix_en), .rgb(b_rgb), .hsync(b_hs), .vsync(b_vs),
    .frame_valid(b_fv), .frame_crc(b_crc), .frame_err(b_err), .frame_cnt(b_cnt), .locked(b_lck)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d, input int nb);
    logic [15:0] r;
    logic        b;
    r = c;
    for (int i = nb - 1; i >= 0; i--) begin
      b = r[15] ^ d[i];
      r = {r[14:0], 1'b0};
      if (b) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Drive one mode-A frame from sync start; columns/lines counted from sync leading edge.
  task automatic frame_a(input int f, input bit grad, input bit toggle, input int long_line,
                         input int vs_lines, input int n_lines, input bit push, input logic [2:0] exp_err);
    logic [15:0] crc;
    logic [11:0] px;
    rep_t        r;
    int          len;
    crc = 16'hFFFF;
    for (int l = 0; l < n_lines; l++) begin
      len = (l == long_line) ? A_HT + 1 : A_HT;
      for (int c = 0; c < len; c++) begin
        px       = grad ? 12'(l * 5 + c * 3 + f * 7) : 12'h03F;
        a_rgb    = px[5:0];
        a_hs     = (c < A_HS) ? 1'b0 : 1'b1;
        a_vs     = (l < vs_lines) ? 1'b0 : 1'b1;
        a_pix_en = 1'b1;
        @(negedge clk);
        if (toggle) begin
          a_pix_en = 1'b0;
          @(negedge clk);
        end
        if (c >= A_HS + A_HB && c < A_HS + A_HB + A_HA && l >= A_VS + A_VB && l < A_VS + A_VB + A_VA)
          crc = crc_step(crc, px, A_CB);
      end
    end
    if (push) begin
      a_exp_cnt = (a_exp_cnt + 1) % 256;
      r.crc = crc;
      r.err = exp_err;
      r.cnt = 8'(a_exp_cnt);
      r.lck = (exp_err == 3'b000);
      qa.push_back(r);
    end
  endtask

  task automatic frame_b(input int f, input bit push);
    logic [15:0] crc;
    logic [11:0] px;
    rep_t        r;
    crc = 16'hFFFF;
    for (int l = 0; l < B_VT; l++) begin
      for (int c = 0; c < B_HT; c++) begin
        px       = 12'(l * 293 + c * 37 + f * 11);
        b_rgb    = px;
        b_hs     = (c < B_HS) ? 1'b1 : 1'b0;
        b_vs     = (l < B_VS) ? 1'b1 : 1'b0;
        b_pix_en = 1'b1;
        @(negedge clk);
        if (c >= B_HS + B_HB && c < B_HS + B_HB + B_HA && l >= B_VS + B_VB && l < B_VS + B_VB + B_VA)
          crc = crc_step(crc, px, B_CB);
      end
    end
    if (push) begin
      b_exp_cnt = (b_exp_cnt + 1) % 256;
      r.crc = crc;
      r.err = 3'b000;
      r.cnt = 8'(b_exp_cnt);
      r.lck = 1'b1;
      qb.push_back(r);
    end
  endtask

  task automatic end_a(input int exp_pulses, input string tag);
    a_pix_en = 1'b0;
    repeat (8) @(negedge clk);
    chk({tag, "_pulses"}, a_pulses, exp_pulses);
    chk({tag, "_queue_left"}, qa.size(), 0);
    a_pulses = 0;
  endtask

  task automatic reset_a();
    a_pix_en = 1'b0;
    a_rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    a_rst_n   = 1'b1;
    a_exp_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (a_fv_prev) chk("a_valid_width", 32'(a_fv), 32'd0);
    if (a_fv) begin
      a_pulses++;
      chk("a_report_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("a_crc", 32'(a_crc), 32'(ea.crc));
        chk("a_err", 32'(a_err), 32'(ea.err));
        chk("a_cnt", 32'(a_cnt), 32'(ea.cnt));
        chk("a_locked", 32'(a_lck), 32'(ea.lck));
      end
    end
    a_fv_prev = a_fv;
  end

  always @(negedge clk) begin
    if (b_fv_prev) chk("b_valid_width", 32'(b_fv), 32'd0);
    if (b_fv) begin
      b_pulses++;
      chk("b_report_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("b_crc", 32'(b_crc), 32'(eb.crc));
        chk("b_err", 32'(b_err), 32'(eb.err));
        chk("b_cnt", 32'(b_cnt), 32'(eb.cnt));
        chk("b_locked", 32'(b_lck), 32'(eb.lck));
      end
    end
    b_fv_prev = b_fv;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst_n = 1'b0; a_pix_en = 1'b0; a_rgb = '0; a_hs = 1'b1; a_vs = 1'b1;
    b_rst_n = 1'b0; b_pix_en = 1'b0; b_rgb = '0; b_hs = 1'b0; b_vs = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(a_fv), 32'd0);
    chk("rst_crc", 32'(a_crc), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_locked", 32'(a_lck), 32'd0);
    chk("rst_b_cnt", 32'(b_cnt), 32'd0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // Three ideal constant frames, pix_en always high.
    for (int f = 0; f < 3; f++) frame_a(f, 1'b0, 1'b0, -1, A_VS, A_VT, f < 2, 3'b000);
    end_a(2, "s1");
    reset_a();

    // Same with pix_en toggling every other cycle.
    for (int f = 0; f < 3; f++) frame_a(f, 1'b0, 1'b1, -1, A_VS, A_VT, f < 2, 3'b000);
    end_a(2, "s2");
    reset_a();

    // One line of H_TOTAL+1 pixels in frame 1.
    for (int f = 0; f < 4; f++)
      frame_a(f, 1'b1, 1'b0, (f == 1) ? 5 : -1, A_VS, A_VT, f < 3, (f == 1) ? 3'b001 : 3'b000);
    end_a(3, "s3");
    reset_a();

    // Three-line vsync in frame 1.
    for (int f = 0; f < 3; f++)
      frame_a(f, 1'b1, 1'b0, -1, (f == 1) ? 3 : A_VS, A_VT, f < 2, (f == 1) ? 3'b100 : 3'b000);
    end_a(2, "s4");
    reset_a();

    // Mid-frame reset, then recovery from SEARCH.
    frame_a(0, 1'b1, 1'b0, -1, A_VS, A_VT, 1'b1, 3'b000);
    frame_a(1, 1'b1, 1'b0, -1, A_VS, A_VT, 1'b1, 3'b000);
    frame_a(2, 1'b1, 1'b0, -1, A_VS, 6, 1'b0, 3'b000);
    end_a(2, "s5_pre");
    a_rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(a_fv), 32'd0);
    chk("midrst_crc", 32'(a_crc), 32'd0);
    chk("midrst_err", 32'(a_err), 32'd0);
    chk("midrst_cnt", 32'(a_cnt), 32'd0);
    chk("midrst_locked", 32'(a_lck), 32'd0);
    a_rst_n   = 1'b1;
    a_exp_cnt = 0;
    for (int f = 0; f < 3; f++) frame_a(f + 10, 1'b1, 1'b0, -1, A_VS, A_VT, f < 2, 3'b000);
    end_a(2, "s5_post");

    // 12-bit active-high 4x3 mode: 261 frames give 260 reports and a frame_cnt wrap.
    for (int f = 0; f < 261; f++) frame_b(f, f < 260);
    b_pix_en = 1'b0;
    repeat (8) @(negedge clk);
    chk("b_pulses", b_pulses, 260);
    chk("b_queue_left", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Synthesizable, parametrised VGA output monitor that sits on the shader's `uo_out` pixel/sync bus (after PMOD unpacking) in both the cocotb bench and the FPGA bring-up build. It recovers frame/line timing from `hsync`/`vsync`, checks sync widths and periods against the configured mode, and computes a per-frame CRC-16 over active-area pixels. It generalises the fixed 6-bit, 640x480, active-low bench wiring to arbitrary colour depth, timing and sync polarity, and adds self-checking that the bench cannot do on its own.

## Interface

Parameters:
- `COLOR_BITS`, 6: pixel colour width (`rrggbb` order, MSB first).
- `H_ACTIVE`, 640: active pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: active lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: sync active level (0 = active-low).

Ports:
- `clk` in 1: clock. One clock domain.
- `rst_n` in 1: reset, synchronous and active-low.
- `pix_en` in 1: pixel strobe. All sampling and counting happen only when it is 1.
- `rgb` in COLOR_BITS: pixel colour.
- `hsync` in 1: horizontal sync, raw polarity.
- `vsync` in 1: vertical sync, raw polarity.
- `frame_valid` out 1: one-`clk` pulse when a frame report is presented.
- `frame_crc` out 16: CRC of the last completed frame.
- `frame_err` out 3: error flags of the last frame: [0] h-period, [1] h-width, [2] v-period or v-width.
- `frame_cnt` out 8: number of reported frames, wraps 255 to 0.
- `locked` out 1: the last reported frame had no errors.

## Operation

- Inputs are registered once on `pix_en` (stage s1), then a second time (stage s2).
- Sync signals are normalised with `SYNC_POL`. A leading edge is s1 active and s2 inactive.
- States:
  - SEARCH: after reset; waits for the first vsync leading edge, then goes to TRACK without producing a report.
  - TRACK: every later vsync leading edge ends the current frame, produces a report and starts the next frame.
- `H_TOTAL` = H_ACTIVE+H_FRONT+H_SYNC+H_BACK. `V_TOTAL` is defined the same way in lines.
- `h_cnt`:
  - cleared to 0 on an hsync leading edge; otherwise +1 per `pix_en` cycle.
  - saturates at its width, which is clog2(H_TOTAL)+1.
- `v_cnt`:
  - cleared by a vsync leading edge.
  - The first hsync leading edge at or after the vsync edge (same cycle counts) marks line 0; each later hsync edge increments it.
- Active pixel:
  - H_SYNC+H_BACK ≤ h_cnt < H_SYNC+H_BACK+H_ACTIVE, and
  - V_SYNC+V_BACK ≤ v_cnt < V_SYNC+V_BACK+V_ACTIVE.
- CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection, no final XOR.
  - Each active pixel feeds all COLOR_BITS bits, MSB first, in one cycle (unrolled).
  - Reset to init at each vsync leading edge.
- Error checks (flags are sticky within a frame):
  - h-period: an hsync edge arrives with h_cnt ≠ H_TOTAL-1, or h_cnt reaches H_TOTAL with no edge. The second case flags only once.
  - h-width: hsync deasserts with h_cnt ≠ H_SYNC-1.
  - v-period: a vsync edge arrives with v_cnt ≠ V_TOTAL-1.
  - v-width: vsync deasserts while v_cnt ≠ V_SYNC-1.
  - The hsync checks for the first line after SEARCH are skipped.
- Report on a frame-ending vsync edge:
  - `frame_crc` takes the final CRC, which includes the pixel in that same cycle only if it is active.
  - `frame_err` takes the sticky flags.
  - `frame_cnt` increments.
  - `locked` is set to (flags == 0).
  - The sticky flags are then cleared.
- Report outputs hold their values until the next report.

## Timing

- Reset values: `frame_valid`=0, `frame_crc`=0x0000, `frame_err`=0, `frame_cnt`=0, `locked`=0, state = SEARCH.
- Latency: `frame_valid` rises 2 `clk` cycles after the `pix_en` cycle in which the vsync leading edge is first present on the input (s1 register, then s2/edge, then report register).
- `frame_valid` is high for exactly one `clk`, independent of `pix_en`.
- `pix_en`=0 freezes every counter, the CRC and both sync stages.
- `rst_n` low at any point, including mid-frame: all state and outputs return to reset values on the next `clk`, and the monitor re-enters SEARCH.
- Simultaneous hsync and vsync leading edges: `v_cnt` goes to 0 and `h_cnt` goes to 0 in that same cycle.

## Test plan

- Default mode, `pix_en`=1, constant rgb=0x3F, three ideal frames:
  - exactly 2 `frame_valid` pulses;
  - `frame_err`=0 and `locked`=1 on both;
  - `frame_cnt` = 1 then 2;
  - `frame_crc` equals the reference-model CRC over 307200 pixels of 0x3F, and is identical on both frames.
- Same as above with `pix_en` toggling every other cycle: identical CRC and counts; each pulse is still one `clk` wide.
- One line with H_TOTAL+1 pixels: that frame reports `frame_err`=3'b001 and `locked`=0; the next clean frame reports 0 and `locked`=1.
- V_SYNC=3 lines instead of 2: `frame_err`[2]=1; `frame_crc` still matches the model.
- `rst_n` pulsed low mid-frame:
  - all outputs read 0 the next cycle;
  - the next vsync produces no pulse;
  - the following frame gives `frame_cnt`=1.
- Parameterisation: COLOR_BITS=12, SYNC_POL=1, 4x3-pixel mode with 1-cycle porches and syncs, gradient pattern. The CRC matches the model for 260 consecutive frames, `frame_cnt` wraps 255 to 0, and `locked` stays 1.
